// File: rtl/fb_pkg.sv
// Shared constants, grant encoding and helpers for the frame-buffer port arbiter.
package fb_pkg;

    localparam int FB_ADDR_W = 17;
    localparam int FB_DATA_W = 12;
    localparam int FB_WORDS  = 76800;

    typedef enum logic [1:0] {
        G_IDLE = 2'd0,
        G_RD   = 2'd1,
        G_WR   = 2'd2
    } grant_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous write-queue FIFO; pointers carry one extra wrap bit so full and empty
// are distinguished without a separate counter register.
module fb_wr_fifo #(
    parameter int W     = 29,
    parameter int DEPTH = 8,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [IW:0]   count
);

    logic [W-1:0] mem [DEPTH];
    logic [IW:0]  wptr;
    logic [IW:0]  rptr;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop && !empty;
    // A push into a full queue is accepted only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    assign count = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (wptr[IW] != rptr[IW]) && (wptr[IW-1:0] == rptr[IW-1:0]);
    assign dout  = mem[rptr[IW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[IW-1:0]] <= din;
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Shares one single-port frame-buffer BRAM between a stall-free reader (fixed 2-cycle
// latency, absolute priority) and a queued writer drained on read-free cycles.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W     = FB_ADDR_W,
    parameter int DATA_W     = FB_DATA_W,
    parameter int FIFO_DEPTH = 8,
    parameter int AFULL_LVL  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              frame_start,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              wq_afull,
    output logic              wq_overflow,
    output logic [15:0]       drop_cnt,
    output grant_e            grant_state
);

    // Handshake: neither requester has backpressure. wr_we is a push that is either
    // queued or counted as dropped; rd_req always returns rd_valid exactly 2 cycles later.
    localparam int EW = ADDR_W + DATA_W;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

    logic [EW-1:0] head;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    grant_e        grant_nxt;
    logic          pop;
    logic          drop;
    logic          rd_pipe;

    always_comb begin
        grant_nxt = G_IDLE;
        if (rd_req)      grant_nxt = G_RD;
        else if (!empty) grant_nxt = G_WR;
    end

    assign pop  = (grant_nxt == G_WR);
    assign drop = wr_we && full && !pop;

    fb_wr_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_we),
        .pop   (pop),
        .din   ({wr_addr, wr_data}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_state <= G_IDLE;
            bram_en     <= 1'b0;
            bram_we     <= 1'b0;
            bram_addr   <= '0;
            bram_din    <= '0;
        end else begin
            grant_state <= grant_nxt;
            case (grant_nxt)
                G_RD: begin
                    bram_en   <= 1'b1;
                    bram_we   <= 1'b0;
                    bram_addr <= rd_addr;
                end
                G_WR: begin
                    bram_en   <= 1'b1;
                    bram_we   <= 1'b1;
                    bram_addr <= head[EW-1:DATA_W];
                    bram_din  <= head[DATA_W-1:0];
                end
                default: begin
                    bram_en <= 1'b0;
                    bram_we <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pipe  <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_pipe  <= rd_req;
            rd_valid <= rd_pipe;
        end
    end

    // An overflow in the frame_start cycle restarts the count at one rather than zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wq_overflow <= 1'b0;
            drop_cnt    <= '0;
        end else if (drop) begin
            wq_overflow <= 1'b1;
            drop_cnt    <= frame_start ? 16'd1 : sat_inc16(drop_cnt);
        end else if (frame_start) begin
            wq_overflow <= 1'b0;
            drop_cnt    <= '0;
        end
    end

    // BRAM output is only meaningful in the valid cycle; zero it elsewhere.
    assign rd_data  = rd_valid ? bram_dout : '0;
    assign wq_afull = (count >= AFULL_C);

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboard bench for fb_port_arbiter: drivers push expected reads/writes, a monitor
// pops and compares whenever the DUT returns read data or issues a BRAM write.
module tb_fb_port_arbiter;
    import fb_pkg::*;

    localparam int AW = 17;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_we = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          frame_start = 1'b0;
    logic          bram_en;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic [DW-1:0] bram_dout = '0;
    logic          wq_afull;
    logic          wq_overflow;
    logic [15:0]   drop_cnt;
    grant_e        grant_state;

    fb_port_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .wr_we       (wr_we),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .frame_start (frame_start),
        .bram_en     (bram_en),
        .bram_we     (bram_we),
        .bram_addr   (bram_addr),
        .bram_din    (bram_din),
        .bram_dout   (bram_dout),
        .wq_afull    (wq_afull),
        .wq_overflow (wq_overflow),
        .drop_cnt    (drop_cnt),
        .grant_state (grant_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #20 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- BRAM model (read-first, 1-cycle latency) ----------------
    logic [DW-1:0] mem   [1 << AW];
    bit            wrote [1 << AW];

    function automatic logic [DW-1:0] pre_val(input logic [AW-1:0] a);
        return DW'(a + 17'h100);
    endfunction

    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) begin
                mem[bram_addr]   <= bram_din;
                wrote[bram_addr] <= 1'b1;
            end
            bram_dout <= wrote[bram_addr] ? mem[bram_addr] : pre_val(bram_addr);
        end
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0]    exp_rd_q[$];
    int               exp_rd_cyc_q[$];
    logic [AW+DW-1:0] exp_wr_q[$];
    int               exp_wr_cyc_q[$];
    bit               exp_wr_exact_q[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor_loop();
        logic [DW-1:0]    e_rd;
        logic [AW+DW-1:0] e_wr;
        int               e_cyc;
        bit               e_exact;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rd_valid) begin
                    if (exp_rd_q.size() == 0) begin
                        check("rd_unexpected", 32'(rd_valid), 32'd0);
                    end else begin
                        e_rd  = exp_rd_q.pop_front();
                        e_cyc = exp_rd_cyc_q.pop_front();
                        check("rd_data", 32'(rd_data), 32'(e_rd));
                        check("rd_latency", cyc, e_cyc);
                    end
                end
                if (bram_en && bram_we) begin
                    if (exp_wr_q.size() == 0) begin
                        check("wr_unexpected", 32'(bram_we), 32'd0);
                    end else begin
                        e_wr    = exp_wr_q.pop_front();
                        e_cyc   = exp_wr_cyc_q.pop_front();
                        e_exact = exp_wr_exact_q.pop_front();
                        check("wr_addr_data", 32'({bram_addr, bram_din}), 32'(e_wr));
                        if (e_exact) check("wr_latency", cyc - e_cyc, 2);
                        else         check("wr_latency_min", 32'((cyc - e_cyc) >= 2), 32'd1);
                    end
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit rd, input bit rd_keep, input int ra,
                         input bit wr, input bit wr_keep, input int wa, input int wd,
                         input bit exact, input bit fs);
        rd_req      = rd;
        rd_addr     = AW'(ra);
        wr_we       = wr;
        wr_addr     = AW'(wa);
        wr_data     = DW'(wd);
        frame_start = fs;
        if (rd && rd_keep) begin
            exp_rd_q.push_back(pre_val(AW'(ra)));
            exp_rd_cyc_q.push_back(cyc + 2);
        end
        if (wr && wr_keep) begin
            exp_wr_q.push_back({AW'(wa), DW'(wd)});
            exp_wr_cyc_q.push_back(cyc);
            exp_wr_exact_q.push_back(exact);
        end
        tick();
        rd_req      = 1'b0;
        wr_we       = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_rd_q.size() != 0 || exp_wr_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_rd_q", exp_rd_q.size(), 0);
        check("drain_wr_q", exp_wr_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_valid"},    32'(rd_valid),    32'd0);
        check({tag, "_rd_data"},     32'(rd_data),     32'd0);
        check({tag, "_bram_en"},     32'(bram_en),     32'd0);
        check({tag, "_bram_we"},     32'(bram_we),     32'd0);
        check({tag, "_bram_addr"},   32'(bram_addr),   32'd0);
        check({tag, "_bram_din"},    32'(bram_din),    32'd0);
        check({tag, "_wq_afull"},    32'(wq_afull),    32'd0);
        check({tag, "_wq_overflow"}, 32'(wq_overflow), 32'd0);
        check({tag, "_drop_cnt"},    32'(drop_cnt),    32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        fork
            monitor_loop();
        join_none

        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) tick();

        // Reads only: addr 0..3 back-to-back, data 0x100..0x103 at +2.
        for (int i = 0; i < 4; i++) drive(1, 1, i, 0, 0, 0, 0, 0, 0);
        wait_drain(20);

        // Writes only: ten pixels, each written exactly 2 cycles after its strobe.
        for (int i = 0; i < 10; i++) drive(0, 0, 0, 1, 1, i, 'hA00 + i, 1, 0);
        wait_drain(30);
        for (int i = 0; i < 10; i++) check("s2_bram_mem", 32'(mem[i]), 32'('hA00 + i));
        check("s2_overflow", 32'(wq_overflow), 32'd0);
        check("s2_drop_cnt", 32'(drop_cnt), 32'd0);

        // Contention: 12 cycles of reads and writes; the last 4 writes are dropped.
        for (int i = 0; i < 12; i++)
            drive(1, 1, 'h300 + i, 1, (i < 8), 'h20 + i, 'hB00 + i, 0, 0);
        check("s3_drop_cnt", 32'(drop_cnt), 32'd4);
        check("s3_overflow", 32'(wq_overflow), 32'd1);
        check("s3_afull", 32'(wq_afull), 32'd1);

        // frame_start clears stats but the 8 queued writes still drain in order.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("s5_overflow_clr", 32'(wq_overflow), 32'd0);
        check("s5_drop_cnt_clr", 32'(drop_cnt), 32'd0);
        wait_drain(40);
        check("s5_afull_after", 32'(wq_afull), 32'd0);

        // Interleave reads and writes every cycle: no drops.
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 'h500 + i, 0, 0, 0, 0, 0, 0);
            drive(0, 0, 0, 1, 1, 'h40 + i, 'hC00 + i, 0, 0);
        end
        check("s4_drop_cnt", 32'(drop_cnt), 32'd0);
        check("s4_overflow", 32'(wq_overflow), 32'd0);
        check("s4_afull", 32'(wq_afull), 32'd0);
        wait_drain(30);

        // Overflow in the frame_start cycle wins: flag=1, count=1.
        for (int i = 0; i < 10; i++)
            drive(1, 1, 'h600 + i, 1, (i < 8), 'h60 + i, 'hD00 + i, 0, (i == 9));
        check("s5b_overflow", 32'(wq_overflow), 32'd1);
        check("s5b_drop_cnt", 32'(drop_cnt), 32'd1);
        wait_drain(40);

        // Reset with 5 queued writes and 2 reads in flight: everything is discarded.
        for (int i = 0; i < 5; i++)
            drive(1, (i < 3), 'h700 + i, 1, 0, 'h80 + i, 'hE00 + i, 0, 0);
        rst = 1'b1;
        #1;
        check_all_zero("s6_async");
        repeat (3) tick();
        rst = 1'b0;
        repeat (12) tick();
        for (int i = 0; i < 5; i++) check("s6_no_write", 32'(wrote['h80 + i]), 32'd0);
        check("s6_rd_q_empty", exp_rd_q.size(), 0);
        check("s6_wr_q_empty", exp_wr_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule
